npu_mem_arb: RTL
================

Name: npu_mem_arb

Overview:
- Two-port arbiter and sequencer in front of one NPU 2048x8 banked scratch RAM (8 x 256x8 banks, bank select on reg_adr[10:8], 1-cycle registered read).
- Shares the RAM between the AHB host path and the NPU compute engine.
- Issues at most one access per cycle and returns read data with a tagged valid pulse.
- NPU has priority, but a starvation counter guarantees the host a slot. An NPU lock holds ownership for bursts.

Parameters:
- ADDR_W, 11, word address width (2048 entries).
- DATA_W, 8, data width.
- MEMSEL_W, 6, width of RAM memory-select field.
- REGSEL_W, 14, width of RAM register-select field.
- MEM_ADDR, 6'b000000, memory-select value driven on every access.
- MAX_WAIT, 8, number of consecutive denied host cycles before a forced host slot; range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- npu_req  in  1  NPU access request, held until npu_gnt
- npu_we  in  1  NPU write (1) / read (0)
- npu_lock  in  1  NPU burst lock, sampled when granted
- npu_addr  in  ADDR_W  NPU word address
- npu_wdata  in  DATA_W  NPU write data
- npu_gnt  out  1  NPU access accepted this cycle
- npu_rvalid  out  1  NPU read data valid
- npu_rdata  out  DATA_W  NPU read data
- host_req  in  1  host access request, held until host_gnt
- host_we  in  1  host write/read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_adr  out  MEMSEL_W  RAM memory select
- reg_adr  out  REGSEL_W  RAM address: {zero pad, addr}
- mem_din  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable, active high
- mem_dout  in  DATA_W  RAM read data, valid 1 cycle after a read access
- starve_cnt  out  8  current host wait count, for debug

Behaviour:
- Reset:
  - Synchronous reset. One clk edge with rst_n=0 gives the reset state.
  - FSM = ARB_NPU, starve_cnt = 0, lock flag = 0, rd_pend = 0, rd_owner = 0.
  - npu_rvalid = host_rvalid = 0; npu_rdata = host_rdata = 0.
  - While rst_n=0, npu_gnt, host_gnt and mem_we are forced 0 combinationally, so no write reaches the RAM during reset.
- Grant is combinational, in the same cycle as the request. The granted requester's addr, wdata and we drive reg_adr, mem_din and mem_we in that cycle.
- When there is no grant:
  - mem_we = 0, reg_adr = 0, mem_din = 0.
  - The RAM still performs a harmless read.
- mem_adr is always MEM_ADDR.
- reg_adr[ADDR_W-1:0] = addr; upper bits are 0.
- FSM states:
  - ARB_NPU (default): grant NPU if npu_req, else host if host_req.
    - Every cycle with host_req=1 and host_gnt=0, starve_cnt increments, saturating at 255.
    - If starve_cnt == MAX_WAIT-1 and this cycle is also denied, go to ARB_HOST.
  - ARB_HOST: grant host if host_req, else NPU. Return to ARB_NPU after one host grant, or immediately if host_req=0.
  - ARB_LOCK: entered when NPU is granted with npu_lock=1. Only NPU is granted. Stay while npu_lock=1 on each NPU grant; exit to ARB_NPU on an NPU grant with npu_lock=0.
  - Lock overrides starvation: in ARB_LOCK, starve_cnt keeps counting. On exit, if the count is >= MAX_WAIT, go to ARB_HOST.
  - Host does not support lock.
- starve_cnt clears to 0 on any host_gnt.
- Read return:
  - On a granted read, the next cycle asserts the owner's rvalid for exactly 1 cycle.
  - The owner's rdata register captures mem_dout in the cycle after the grant and holds it until that owner's next read return.
  - The other owner's rvalid/rdata are unaffected.
  - Back-to-back reads, including alternating owners, give one rvalid per cycle with correct routing.
- Writes produce no rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM ordering). The arbiter adds no hazard logic.
- Reset mid-operation: a pending rvalid is dropped; FSM, lock and counter return to reset values.
- Simultaneous requests in ARB_NPU: NPU wins. In ARB_HOST: host wins.

Decomposition:
- Shared package npu_mem_pkg:
  - arb_state_t enum (ARB_NPU, ARB_HOST, ARB_LOCK).
  - Owner encoding constants OWN_NPU = 1'b0, OWN_HOST = 1'b1.
  - NPU_MEM_ADDR_W = 11.
- One sub-module, npu_mem_rdret: registers rd_pend and rd_owner, and demuxes mem_dout into per-owner rdata/rvalid.
- Arbitration FSM and starve counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both req=1, we=1 -> gnt=0, mem_we=0 throughout; after release all outputs are 0 and FSM = ARB_NPU.
- Basic write then read:
  - Host writes 0xA5 at addr 0x3FF: mem_we=1, reg_adr=0x03FF.
  - Host read of 0x3FF -> host_rvalid 1 cycle later, host_rdata=0xA5; npu_rvalid stays 0.
- Bank sweep: NPU writes addr i with data i^0x5A for i = 0x000, 0x100, ..., 0x700, then reads them back-to-back -> 8 consecutive npu_rvalid pulses with matching data.
- Starvation: npu_req held at 1 and host_req=1 from cycle 0 with MAX_WAIT=8 -> host_gnt in exactly cycle 8, starve_cnt returns to 0, NPU is granted again at cycle 9.
- Lock: NPU issues 4 reads with npu_lock=1,1,1,0 while host_req=1 -> host is not granted during the burst. starve_cnt counts to 4; host is granted in the first cycle after the burst only if 4 >= MAX_WAIT (test MAX_WAIT=3 -> host granted immediately after the burst).
- Alternating reads: NPU reads 0x010 (data 0x11) and host reads 0x020 (data 0x22) in consecutive cycles -> npu_rvalid then host_rvalid in consecutive cycles with rdata 0x11 / 0x22 and no cross-routing; rst_n pulsed low in the cycle after the host grant -> host_rvalid is suppressed.

Source files
------------

// File: rtl/npu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_mem_pkg
// Description : Shared types and constants for the NPU scratch-RAM arbiter:
//               arbitration state encoding, read-owner encoding and a
//               saturating 8-bit increment used by the starvation counter.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_mem_pkg;

    // Word address width of the 2048-entry banked scratch RAM
    localparam int NPU_MEM_ADDR_W = 11;

    // Owner tag carried alongside an outstanding read
    localparam logic OWN_NPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    // Who currently holds arbitration preference
    typedef enum logic [1:0] {
        ARB_NPU  = 2'd0,
        ARB_HOST = 2'd1,
        ARB_LOCK = 2'd2
    } arb_state_t;

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/npu_mem_rdret.sv
`default_nettype none
// ============================================================================
// Module      : npu_mem_rdret
// Description : Read-return path. Remembers whether the previous cycle issued
//               a read and for whom, then steers the RAM output to that
//               owner's rvalid/rdata. Each owner's rdata is held until its
//               next read return.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_mem_rdret
    import npu_mem_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_issue,
    input  logic              i_rd_owner,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic              o_npu_rvalid,
    output logic [DATA_W-1:0] o_npu_rdata,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata
);

    logic              r_rd_pend;
    logic              r_rd_owner;
    logic [DATA_W-1:0] r_npu_rdata;
    logic [DATA_W-1:0] r_host_rdata;
    logic              w_npu_hit;
    logic              w_host_hit;

    // RAM data is valid the cycle after the grant; reset drops it immediately
    assign w_npu_hit  = rst_n & r_rd_pend & (r_rd_owner == OWN_NPU);
    assign w_host_hit = rst_n & r_rd_pend & (r_rd_owner == OWN_HOST);

    // Track the outstanding read and keep the last returned word per owner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= OWN_NPU;
            r_npu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            r_rd_pend <= i_rd_issue;
            if (i_rd_issue) begin
                r_rd_owner <= i_rd_owner;
            end
            if (w_npu_hit) begin
                r_npu_rdata <= i_mem_dout;
            end
            if (w_host_hit) begin
                r_host_rdata <= i_mem_dout;
            end
        end
    end

    assign o_npu_rvalid  = w_npu_hit;
    assign o_host_rvalid = w_host_hit;
    assign o_npu_rdata   = w_npu_hit  ? i_mem_dout : r_npu_rdata;
    assign o_host_rdata  = w_host_hit ? i_mem_dout : r_host_rdata;

endmodule
`default_nettype wire

// File: rtl/npu_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : npu_mem_arb
// Description : Two-port arbiter in front of the NPU banked scratch RAM.
//               NPU has priority; a starvation counter forces a host slot
//               after MAX_WAIT denied cycles; an NPU lock holds ownership
//               for bursts. One access per cycle, combinational grant.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_mem_arb
    import npu_mem_pkg::*;
#(
    parameter int                  ADDR_W   = NPU_MEM_ADDR_W,
    parameter int                  DATA_W   = 8,
    parameter int                  MEMSEL_W = 6,
    parameter int                  REGSEL_W = 14,
    parameter logic [MEMSEL_W-1:0] MEM_ADDR = 6'b000000,
    parameter int                  MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                npu_req,
    input  logic                npu_we,
    input  logic                npu_lock,
    input  logic [ADDR_W-1:0]   npu_addr,
    input  logic [DATA_W-1:0]   npu_wdata,
    output logic                npu_gnt,
    output logic                npu_rvalid,
    output logic [DATA_W-1:0]   npu_rdata,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    output logic                host_gnt,
    output logic                host_rvalid,
    output logic [DATA_W-1:0]   host_rdata,
    output logic [MEMSEL_W-1:0] mem_adr,
    output logic [REGSEL_W-1:0] reg_adr,
    output logic [DATA_W-1:0]   mem_din,
    output logic                mem_we,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic [7:0]          starve_cnt
);

    localparam logic [7:0] c_max_wait  = 8'(MAX_WAIT);
    localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [7:0]        r_starve_cnt;
    logic [7:0]        w_starve_nxt;
    logic              w_npu_gnt;
    logic              w_host_gnt;
    logic              w_host_denied;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic              w_we;
    logic              w_rd_issue;

    // Grant selection, host wait count update and next ownership state
    always_comb begin
        w_npu_gnt   = 1'b0;
        w_host_gnt  = 1'b0;
        w_state_nxt = r_state;

        case (r_state)
            ARB_HOST: begin
                w_host_gnt = host_req;
                w_npu_gnt  = npu_req & ~host_req;
            end
            ARB_LOCK: begin
                w_npu_gnt = npu_req;
            end
            default: begin
                w_npu_gnt  = npu_req;
                w_host_gnt = host_req & ~npu_req;
            end
        endcase

        // Nothing may reach the RAM while reset is asserted
        if (!rst_n) begin
            w_npu_gnt  = 1'b0;
            w_host_gnt = 1'b0;
        end

        w_host_denied = host_req & ~w_host_gnt;
        w_starve_nxt  = w_host_gnt    ? 8'd0 :
                        w_host_denied ? sat_inc8(r_starve_cnt) : r_starve_cnt;

        case (r_state)
            ARB_NPU: begin
                // A lock request beats a pending starvation hand-over;
                // the count keeps running and is re-examined at unlock
                if (w_npu_gnt && npu_lock) begin
                    w_state_nxt = ARB_LOCK;
                end else if (w_host_denied && (r_starve_cnt == c_wait_last)) begin
                    w_state_nxt = ARB_HOST;
                end
            end
            ARB_HOST: begin
                // The forced slot lasts one cycle: used by the host, or
                // given back at once when the host is idle
                if (w_npu_gnt && npu_lock) begin
                    w_state_nxt = ARB_LOCK;
                end else begin
                    w_state_nxt = ARB_NPU;
                end
            end
            ARB_LOCK: begin
                if (w_npu_gnt && !npu_lock) begin
                    w_state_nxt = (w_starve_nxt >= c_max_wait) ? ARB_HOST : ARB_NPU;
                end
            end
            default: begin
                w_state_nxt = ARB_NPU;
            end
        endcase
    end

    // Ownership state and host starvation counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ARB_NPU;
            r_starve_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Route the granted requester onto the RAM port; idle cycles drive zeros
    always_comb begin
        w_addr = '0;
        w_din  = '0;
        w_we   = 1'b0;
        if (w_host_gnt) begin
            w_addr = host_addr;
            w_din  = host_wdata;
            w_we   = host_we;
        end else if (w_npu_gnt) begin
            w_addr = npu_addr;
            w_din  = npu_wdata;
            w_we   = npu_we;
        end
    end

    // Zero-extend the word address into the RAM register-select field
    always_comb begin
        reg_adr               = '0;
        reg_adr[ADDR_W-1:0]   = w_addr;
    end

    assign w_rd_issue = (w_npu_gnt | w_host_gnt) & ~w_we;

    assign npu_gnt    = w_npu_gnt;
    assign host_gnt   = w_host_gnt;
    assign mem_adr    = MEM_ADDR;
    assign mem_din    = w_din;
    assign mem_we     = w_we;
    assign starve_cnt = r_starve_cnt;

    npu_mem_rdret #(
        .DATA_W (DATA_W)
    ) u_rdret (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rd_issue    (w_rd_issue),
        .i_rd_owner    (w_host_gnt ? OWN_HOST : OWN_NPU),
        .i_mem_dout    (mem_dout),
        .o_npu_rvalid  (npu_rvalid),
        .o_npu_rdata   (npu_rdata),
        .o_host_rvalid (host_rvalid),
        .o_host_rdata  (host_rdata)
    );

endmodule
`default_nettype wire
